// File: rtl/uart_frame_loader.sv
// Deframes the UART byte stream into RGB pixels, writes them into the back bank
// of the double-buffered frame RAM, and swaps banks once the checksum matches.
module uart_frame_loader #(
    parameter int          PIXELS       = 1024,
    parameter int          ADDR_W       = 10,
    parameter logic [7:0]  SYNC0        = 8'hA5,
    parameter logic [7:0]  SYNC1        = 8'h5A,
    parameter int          TIMEOUT_CLKS = 2_500_000
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_complete,
    output logic              o_wr_en,
    output logic              o_wr_bank,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [23:0]       o_wr_data,
    output logic              o_disp_bank,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int IDLE_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        S_SYNC0 = 2'd0,
        S_SYNC1 = 2'd1,
        S_DATA  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rx_prev_q, rx_prev_d;
    logic                armed_q, armed_d;
    logic [ADDR_W-1:0]   pix_q, pix_d;
    logic [1:0]          phase_q, phase_d;
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          red_q, red_d;
    logic [7:0]          grn_q, grn_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [23:0]         wr_data_q, wr_data_d;
    logic                disp_bank_q, disp_bank_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic                byte_stb_s;
    logic                timeout_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        phase_d      = phase_q;
        sum_d        = sum_q;
        red_d        = red_q;
        grn_d        = grn_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        disp_bank_d  = disp_bank_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        rx_prev_d    = i_rx_complete;
        // A line already high at reset release must fall once before a strobe counts.
        armed_d      = armed_q | ~i_rx_complete;
        byte_stb_s   = i_rx_complete & ~rx_prev_q & armed_q;

        if ((state_q == S_SYNC0) || byte_stb_s) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end else begin
            idle_d = idle_q;
        end
        timeout_s = (state_q != S_SYNC0) && !byte_stb_s && (idle_q == IDLE_LAST);

        case (state_q)
            S_SYNC0: begin
                if (byte_stb_s && (i_rx_byte == SYNC0)) begin
                    state_d = S_SYNC1;
                end else begin
                    state_d = S_SYNC0;
                end
            end
            S_SYNC1: begin
                if (byte_stb_s) begin
                    if (i_rx_byte == SYNC1) begin
                        state_d = S_DATA;
                        pix_d   = '0;
                        phase_d = 2'd0;
                        sum_d   = 8'd0;
                    end else if (i_rx_byte == SYNC0) begin
                        state_d = S_SYNC1;
                    end else begin
                        state_d = S_SYNC0;
                    end
                end else begin
                    state_d = S_SYNC1;
                end
            end
            S_DATA: begin
                if (byte_stb_s) begin
                    sum_d = sum_q + i_rx_byte;
                    case (phase_q)
                        2'd0: begin
                            red_d   = i_rx_byte;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            grn_d   = i_rx_byte;
                            phase_d = 2'd2;
                        end
                        2'd2: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pix_q;
                            wr_data_d = {red_q, grn_q, i_rx_byte};
                            phase_d   = 2'd0;
                            // The last pixel hands over to the checksum rather than wrapping.
                            if (pix_q == PIX_LAST) begin
                                state_d = S_CHECK;
                            end else begin
                                pix_d = pix_q + 1'b1;
                            end
                        end
                        default: begin
                            phase_d = 2'd0;
                        end
                    endcase
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (byte_stb_s) begin
                    state_d = S_SYNC0;
                    if (i_rx_byte == sum_q) begin
                        frame_done_d = 1'b1;
                        disp_bank_d  = ~disp_bank_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_SYNC0;
            end
        endcase

        if (timeout_s) begin
            state_d     = S_SYNC0;
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = frame_err_d;
        end

        wr_bank_d = ~disp_bank_d;
        busy_d    = (state_d != S_SYNC0);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_SYNC0;
            rx_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            pix_q        <= '0;
            phase_q      <= 2'd0;
            sum_q        <= 8'd0;
            red_q        <= 8'd0;
            grn_q        <= 8'd0;
            idle_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_bank_q    <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= 24'd0;
            disp_bank_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_prev_d;
            armed_q      <= armed_d;
            pix_q        <= pix_d;
            phase_q      <= phase_d;
            sum_q        <= sum_d;
            red_q        <= red_d;
            grn_q        <= grn_d;
            idle_q       <= idle_d;
            wr_en_q      <= wr_en_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            disp_bank_q  <= disp_bank_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_bank    = wr_bank_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_disp_bank  = disp_bank_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_err  = frame_err_q;
    assign o_busy       = busy_q;

endmodule
